// File: rtl/conv_operand_loader_pkg.sv
// Shared definitions for the convolution operand loader.
package conv_operand_loader_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_KICK = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int N_INPUT            = 16;
  localparam int N_FILTER           = 9;
  localparam int N_FRAME            = N_INPUT + N_FILTER;
  localparam int IDX_W              = 5;
  localparam int DEF_COMPUTE_CYCLES = 34;

  // Counter width able to hold 0..cycles.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/conv_operand_loader_cycle_counter.sv
// Loadable up-counter with a terminal-count compare; times the core compute window.
module conv_operand_loader_cycle_counter #(
  parameter int W        = 6,
  parameter int TERMINAL = 33
) (
  input  logic clk_in,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority over counting so a kick always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)    cnt_d = '0;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  // Counter register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == W'(TERMINAL));

endmodule

// File: rtl/conv_operand_loader.sv
// Byte-serial operand loader for the 3x3/4x4 systolic convolution core.
// Collects a frame into held input/filter registers, kicks the core, times the
// compute window and flags done. Optional LOADER_FILTER_KEEP_EN adds filter_keep,
// letting a frame stop after the 16 input bytes and reuse the held filter.
module conv_operand_loader
  import conv_operand_loader_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int COMPUTE_CYCLES = DEF_COMPUTE_CYCLES
) (
  input  logic                       clk_in,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
`ifdef LOADER_FILTER_KEEP_EN
  input  logic                       filter_keep,
`endif
  output logic [N_INPUT*DATA_W-1:0]  i_flat,
  output logic [N_FILTER*DATA_W-1:0] f_flat,
  output logic                       core_rst,
  output logic                       busy,
  output logic                       done,
  input  logic                       done_ack
);

  localparam int CNT_W = cnt_width(COMPUTE_CYCLES);

  state_e                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [N_INPUT-1:0][DATA_W-1:0]     i_q, i_d;
  logic [N_FILTER-1:0][DATA_W-1:0]    f_q, f_d;
  logic                               accept;
  logic                               frame_end;
  logic                               cnt_load, cnt_en, cnt_tc;

  assign accept = in_valid && in_ready;

  // Last byte of the frame: always slot 24, or slot 15 when the filter is kept.
`ifdef LOADER_FILTER_KEEP_EN
  assign frame_end = (idx_q == IDX_W'(N_FRAME - 1)) ||
                     ((idx_q == IDX_W'(N_INPUT - 1)) && filter_keep);
`else
  assign frame_end = (idx_q == IDX_W'(N_FRAME - 1));
`endif

  // Next-state, slot writes and counter control.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    i_d      = i_q;
    f_d      = f_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          for (int s = 0; s < N_INPUT; s++)
            if (idx_q == IDX_W'(s)) i_d[s] = in_data;
          for (int s = 0; s < N_FILTER; s++)
            if (idx_q == IDX_W'(N_INPUT + s)) f_d[s] = in_data;
          if (frame_end) begin
            state_d = ST_KICK;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_KICK: begin
        cnt_load = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (cnt_tc) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (done_ack) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // State, index and operand registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      i_q     <= '0;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      i_q     <= i_d;
      f_q     <= f_d;
    end
  end

  conv_operand_loader_cycle_counter #(
    .W        (CNT_W),
    .TERMINAL (COMPUTE_CYCLES - 1)
  ) u_cnt (
    .clk_in (clk_in),
    .rst    (rst),
    .load   (cnt_load),
    .en     (cnt_en),
    .tc     (cnt_tc)
  );

  // All handshake/status outputs decode the registered state.
  assign in_ready = (state_q == ST_LOAD);
  assign core_rst = (state_q == ST_KICK);
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign i_flat   = i_q;
  assign f_flat   = f_q;

endmodule

// File: tb/tb_conv_operand_loader.sv
// Scoreboard bench for conv_operand_loader: frames push expected operands,
// a monitor compares them at each core kick and checks kick-to-done latency.
`timescale 1ns/1ps
module tb_conv_operand_loader;

  localparam int DW = 8;
  localparam int CC = 34;

  typedef struct packed {
    logic [16*DW-1:0] i;
    logic [9*DW-1:0]  f;
  } frame_t;

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic [DW-1:0]    in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [16*DW-1:0] i_flat;
  logic [9*DW-1:0]  f_flat;
  logic             core_rst, busy, done;
  logic             done_ack = 1'b0;
`ifdef LOADER_FILTER_KEEP_EN
  logic             filter_keep = 1'b0;
`endif

  conv_operand_loader #(.DATA_W(DW), .COMPUTE_CYCLES(CC)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
`ifdef LOADER_FILTER_KEEP_EN
    .filter_keep (filter_keep),
`endif
    .i_flat   (i_flat),
    .f_flat   (f_flat),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done),
    .done_ack (done_ack)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  frame_t           exp_q[$];
  logic [16*DW-1:0] model_i = '0;
  logic [9*DW-1:0]  model_f = '0;

  // Monitor: compare operands on each kick, then time the done rise.
  int   kick_cyc = 0;
  bit   wait_done = 1'b0;
  logic done_prev = 1'b0;
  logic kick_prev = 1'b0;
  always @(negedge clk_in) begin
    if (!rst) begin
      if (core_rst) begin
        chk("kick_single_cycle", 128'(kick_prev), 128'(0));
        if (exp_q.size() == 0) begin
          chk("kick_expected", 128'(core_rst), 128'(0));
        end else begin
          frame_t e;
          e = exp_q.pop_front();
          chk("kick_i_flat", 128'(i_flat), 128'(e.i));
          chk("kick_f_flat", 128'(f_flat), 128'(e.f));
          kick_cyc  = cyc;
          wait_done = 1'b1;
        end
      end
      if (done && !done_prev && wait_done) begin
        chk("kick_to_done", 128'(cyc - kick_cyc), 128'(CC + 1));
        wait_done = 1'b0;
      end
    end
    done_prev = done;
    kick_prev = core_rst;
  end

  // Stream a full frame starting at value base; pushes the expected operands.
  task automatic send_frame(input int base, input int n, input bit toggle);
    frame_t e;
    e.i = model_i;
    e.f = model_f;
    for (int k = 0; k < n; k++) begin
      if (k < 16) e.i[k*DW +: DW] = DW'(base + k);
      else        e.f[(k-16)*DW +: DW] = DW'(base + k);
    end
    model_i = e.i;
    model_f = e.f;
    exp_q.push_back(e);
`ifdef LOADER_FILTER_KEEP_EN
    filter_keep = (n == 16);
`endif
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(base + k);
      chk("in_ready_load", 128'(in_ready), 128'(1));
      @(negedge clk_in);
      if (k != n - 1) chk("no_early_kick", 128'(core_rst), 128'(0));
      if (toggle) begin
        in_valid = 1'b0;
        in_data  = 8'hA5;
        @(negedge clk_in);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done_bounded();
    for (int t = 0; t < 100 && !done; t++) @(negedge clk_in);
    chk("done_reached", 128'(done), 128'(1));
  endtask

  task automatic ack();
    done_ack = 1'b1;
    in_valid = 1'b0;
    @(negedge clk_in);
    done_ack = 1'b0;
    chk("ack_done_low", 128'(done), 128'(0));
    chk("ack_ready_high", 128'(in_ready), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk_in);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_core_rst", 128'(core_rst), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_i_flat", 128'(i_flat), 128'(0));
    chk("rst_f_flat", 128'(f_flat), 128'(0));
    rst = 1'b0;
    @(negedge clk_in);

    // 1: continuous stream 1..25; 3: junk offered during RUN/DONE
    send_frame(1, 25, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (3) @(negedge clk_in);
    chk("run_busy", 128'(busy), 128'(1));
    chk("run_ready_low", 128'(in_ready), 128'(0));
    wait_done_bounded();
    chk("i00", 128'(i_flat[7:0]), 128'(1));
    chk("i33", 128'(i_flat[127:120]), 128'(16));
    chk("f00", 128'(f_flat[7:0]), 128'(17));
    chk("f22", 128'(f_flat[71:64]), 128'(25));
    // 5: done held while unacknowledged
    for (int t = 0; t < 20; t++) begin
      @(negedge clk_in);
      chk("done_hold", 128'(done), 128'(1));
      chk("done_ready_low", 128'(in_ready), 128'(0));
    end
    chk("hold_i_flat", 128'(i_flat), 128'(model_i));
    chk("hold_f_flat", 128'(f_flat), 128'(model_f));
    ack();

    // 2: same stream with in_valid toggling
    send_frame(1, 25, 1'b1);
    wait_done_bounded();
    chk("tog_i00", 128'(i_flat[7:0]), 128'(1));
    chk("tog_f22", 128'(f_flat[71:64]), 128'(25));
    ack();

    // 4: reset mid-frame, then a fresh frame 100..124
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(50 + k);
      @(negedge clk_in);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    model_i = '0;
    model_f = '0;
    #1;
    chk("midrst_i_flat", 128'(i_flat), 128'(0));
    chk("midrst_f_flat", 128'(f_flat), 128'(0));
    chk("midrst_ready", 128'(in_ready), 128'(1));
    @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    send_frame(100, 25, 1'b0);
    wait_done_bounded();
    chk("new_i00", 128'(i_flat[7:0]), 128'(100));
    chk("new_i01", 128'(i_flat[15:8]), 128'(101));
    chk("new_f22", 128'(f_flat[71:64]), 128'(124));
    ack();

`ifdef LOADER_FILTER_KEEP_EN
    // 6: full frame, then a 16-byte frame keeping the filter
    send_frame(30, 25, 1'b0);
    wait_done_bounded();
    ack();
    send_frame(200, 16, 1'b0);
    wait_done_bounded();
    chk("keep_i00", 128'(i_flat[7:0]), 128'(200));
    chk("keep_f00", 128'(f_flat[7:0]), 128'(46));
    chk("keep_f22", 128'(f_flat[71:64]), 128'(54));
    ack();
`endif

    repeat (2) @(negedge clk_in);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_operand_loader.md
Name: conv_operand_loader

Overview:
Upstream feeder for the 3x3-filter / 4x4-input systolic convolution core. Accepts a byte-serial operand stream with a valid/ready handshake. Assembles the stream into a held 4x4 input matrix and a 3x3 filter matrix, then kicks the core with a one-cycle restart pulse. It counts the core's compute window and raises a done flag for the result consumer.

Parameters:
DATA_W, 8, operand width in bits.
COMPUTE_CYCLES, 34, cycles from kick to results stable at the core outputs (core stops at count 32, plus 2 cycles of margin).

Ports:
clk_in  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
in_data  input  DATA_W  operand byte.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  loader accepts a byte this cycle.
i_flat  output  16*DATA_W  input matrix, row-major; i00 occupies bits [DATA_W-1:0], i33 occupies the top slice.
f_flat  output  9*DATA_W  filter matrix, row-major; f00 occupies bits [DATA_W-1:0].
core_rst  output  1  one-cycle restart pulse to the core; ORed into the core's rst externally.
busy  output  1  core compute window in progress.
done  output  1  results valid at the core outputs.
done_ack  input  1  consumer has taken the results.

Behaviour:
- Reset values: state LOAD, byte index 0, i_flat=0, f_flat=0, in_ready=1, core_rst=0, busy=0, done=0.
- A byte is accepted on any cycle where in_valid and in_ready are both 1. in_ready is a function of state only: it is 1 in LOAD and 0 in every other state.
- LOAD:
  - Accepted byte n (0..24) is written to slot n.
  - Slots 0..15 are i00..i33; slots 16..24 are f00..f22.
  - The index increments per accepted byte.
  - On acceptance of byte 24, go to KICK and reset the index to 0.
  - in_valid=0 stalls with no state change.
- KICK: core_rst=1 for exactly this one cycle; load the cycle counter with 0; go to RUN.
- RUN:
  - busy=1 and the counter increments each cycle.
  - When counter == COMPUTE_CYCLES-1, go to DONE.
  - Total kick-to-done latency is COMPUTE_CYCLES+1 cycles.
- DONE:
  - done=1 and held.
  - When done_ack=1, go to LOAD next cycle; done falls in that same cycle.
- i_flat/f_flat change only on accepted bytes. They hold through KICK, RUN and DONE, so core operands are stable for the entire computation.
- Operand registers keep their previous contents while a new frame loads. A slot updates only when its byte arrives.
- Widths:
  - Byte index is 5 bits and saturates at no value; it is always cleared on the 24->KICK transition.
  - Cycle counter is ceil(log2(COMPUTE_CYCLES+1)) bits.
- done_ack outside DONE is ignored.
- in_valid outside LOAD is ignored, and nothing is accepted.
- rst asserted at any time (mid-load, mid-run):
  - Immediate return to reset values.
  - A partial frame is discarded and the next frame starts at slot 0.
  - core_rst is not driven by rst; the core receives rst directly.

Optional Feature:
Macro LOADER_FILTER_KEEP_EN.
- Defined:
  - Adds input port filter_keep (1 bit), sampled when byte 15 is accepted.
  - If filter_keep=1 at that point, go directly to KICK after byte 15; f_flat retains the previous frame's filter and slots 16..24 are skipped.
  - If filter_keep=0 at that point, the normal 25-byte frame applies.
- Undefined: port absent; every frame is 25 bytes.

Decomposition:
- Shared package holds:
  - state enum (LOAD, KICK, RUN, DONE), 2-bit encoding;
  - constants N_INPUT=16, N_FILTER=9, N_FRAME=25;
  - default COMPUTE_CYCLES.
- One natural sub-module: loader_cycle_counter. It is a loadable up-counter with a terminal-count compare and is reused for the RUN window.
- Operand storage stays inline as an indexed register bank.

Test Plan:
1. Reset, then stream bytes 1..25 with in_valid held high:
   - in_ready is high for 25 cycles;
   - i00=1, i33=16, f00=17, f22=25;
   - core_rst pulses once in the cycle after byte 25;
   - done rises COMPUTE_CYCLES+1 (35) cycles after core_rst.
2. Same stream with in_valid toggling 1/0:
   - identical register contents to scenario 1;
   - KICK only after the 25th accepted byte;
   - zero-valid cycles are not counted.
3. Drive in_valid=1 with data 0xFF during RUN and DONE:
   - in_ready=0;
   - i_flat and f_flat unchanged.
4. Assert rst after 10 bytes, then stream 25 new bytes 100..124:
   - i00=100, f22=124;
   - no stale slot offset.
5. Hold done_ack=0 for 20 cycles in DONE:
   - done stays 1;
   - assert done_ack for 1 cycle, then done=0 and in_ready=1 on the next cycle.
6. With LOADER_FILTER_KEEP_EN defined:
   - first frame: 25 bytes with filter_keep=0;
   - second frame: 16 bytes (200..215) with filter_keep=1;
   - required: KICK after the 16th byte, f_flat equal to the first frame's filter, i00=200.
